brent_kung_subtractor_pipe: RTL and testbench

//  Pipelined WIDTH-bit subtractor computing D = A - B - borrow_in with a Brent-Kung prefix borrow network.

---
 rtl/brent_kung_subtractor_pipe_pkg.sv | 25 ++
 rtl/brent_kung_subtractor_pipe_if.sv | 30 +++
 rtl/brent_kung_subtractor_pipe_gp_cell.sv | 16 +
 rtl/brent_kung_subtractor_pipe.sv | 161 ++++++++++++++++
 tb/tb_brent_kung_subtractor_pipe.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/brent_kung_subtractor_pipe_pkg.sv
// Purpose : shared definitions for the pipelined Brent-Kung subtractor.
//           Holds the default operand width, the per-bit generate/propagate
//           pair type, and the clog2 helper used to check the prefix depth.
// Ports   : none (package).
package brent_kung_subtractor_pipe_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int LOG_W_DEF = 6;

    // One bit position (or group) of the borrow network: g = generate, p = propagate.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/brent_kung_subtractor_pipe_if.sv
// Purpose : valid/ready stream bundle for the Brent-Kung subtractor.
//   in_valid/in_ready/in_a/in_b/in_borrow : operand side (producer -> block)
//   out_valid/out_ready/out_diff/out_borrow : result side (block -> consumer)
// Modports: slave = the subtractor, master = the environment driving it.
interface brent_kung_subtractor_pipe_if
    import brent_kung_subtractor_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_borrow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;

    modport slave (
        input  in_valid, in_a, in_b, in_borrow, out_ready,
        output in_ready, out_valid, out_diff, out_borrow
    );

    modport master (
        output in_valid, in_a, in_b, in_borrow, out_ready,
        input  in_ready, out_valid, out_diff, out_borrow
    );

endinterface

// File: rtl/brent_kung_subtractor_pipe_gp_cell.sv
// Purpose : one Brent-Kung prefix combine of a higher (hi) and lower (lo)
//           group: G = g_hi | p_hi & g_lo, P = p_hi & p_lo.
// Ports   : i_hi  in  gp_t  higher-order group
//           i_lo  in  gp_t  adjacent lower-order group
//           o_gp  out gp_t  merged group
module brent_kung_subtractor_pipe_gp_cell
    import brent_kung_subtractor_pipe_pkg::*;
(
    input  gp_t i_hi,
    input  gp_t i_lo,
    output gp_t o_gp
);

    assign o_gp = '{g: i_hi.g | (i_hi.p & i_lo.g), p: i_hi.p & i_lo.p};

endmodule

// File: rtl/brent_kung_subtractor_pipe.sv
// Purpose : three-stage pipelined subtractor D = A - B - borrow_in, computed
//           as A + ~B + ~borrow_in with a Brent-Kung prefix carry network.
//           out_borrow is the inverted carry out.
// Ports   : clk  in  clock, rising edge
//           rst  in  synchronous active-high reset
//           bus  slave modport of brent_kung_subtractor_pipe_if
//                (in_valid/in_ready/in_a/in_b/in_borrow,
//                 out_valid/out_ready/out_diff/out_borrow)
module brent_kung_subtractor_pipe
    import brent_kung_subtractor_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LOG_W = LOG_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    brent_kung_subtractor_pipe_if.slave     bus
);

    if (WIDTH != (1 << LOG_W) || LOG_W != clog2(WIDTH) || WIDTH < 8) begin : g_bad_param
        $error("brent_kung_subtractor_pipe: WIDTH must be 2**LOG_W and >= 8");
    end

    genvar gl, gk, gi;

    logic             r_vld_p1, r_vld_p2, r_vld_p3;
    logic             w_adv1, w_adv2, w_adv3;

    logic [WIDTH-1:0] r_g_p1, r_p_p1;
    logic             r_c0_p1;
    logic [WIDTH-1:0] w_g_in, w_up_g, w_up_p;

    logic [WIDTH-1:0] r_g_p2, r_gp_p2, r_p_p2;
    logic             r_c0_p2;
    logic [WIDTH-1:0] w_pre_g, w_unused_pre_p, w_carry, w_diff;
    logic             w_borrow;

    logic [WIDTH-1:0] r_diff_p3;
    logic             r_borrow_p3;

    // Stall chain: a stage moves when it is empty or its successor moves.
    // in_ready is combinational from out_ready through this chain.
    assign w_adv3       = !r_vld_p3 || bus.out_ready;
    assign w_adv2       = !r_vld_p2 || w_adv3;
    assign w_adv1       = !r_vld_p1 || w_adv2;
    assign bus.in_ready = !rst && w_adv1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else begin
            if (w_adv1) r_vld_p1 <= bus.in_valid;
            if (w_adv2) r_vld_p2 <= r_vld_p1;
            if (w_adv3) r_vld_p3 <= r_vld_p2;
        end
    end

    // ---- Stage 1: per-bit generate/propagate of A + ~B, carry-in = ~borrow_in
    always_ff @(posedge clk) begin
        if (w_adv1 && bus.in_valid) begin
            r_p_p1  <= bus.in_a ^ ~bus.in_b;
            r_g_p1  <= bus.in_a & ~bus.in_b;
            r_c0_p1 <= ~bus.in_borrow;
        end
    end

    // ---- Stage 2: up-sweep
    // Folding the carry-in into bit 0 makes every prefix G[i:0] the carry into bit i+1.
    assign w_g_in = {r_g_p1[WIDTH-1:1], r_g_p1[0] | (r_p_p1[0] & r_c0_p1)};

    for (gl = 0; gl < LOG_W; gl++) begin : g_up
        logic [WIDTH-1:0] w_prev_g, w_prev_p, w_g, w_p;
        if (gl == 0) begin : g_src
            assign w_prev_g = w_g_in;
            assign w_prev_p = r_p_p1;
        end else begin : g_src
            assign w_prev_g = g_up[gl-1].w_g;
            assign w_prev_p = g_up[gl-1].w_p;
        end
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (((gi + 1) % (1 << (gl + 1))) == 0) begin : g_node
                gp_t w_o;
                brent_kung_subtractor_pipe_gp_cell u_cell (
                    .i_hi (gp_t'({w_prev_g[gi], w_prev_p[gi]})),
                    .i_lo (gp_t'({w_prev_g[gi - (1 << gl)], w_prev_p[gi - (1 << gl)]})),
                    .o_gp (w_o)
                );
                assign w_g[gi] = w_o.g;
                assign w_p[gi] = w_o.p;
            end else begin : g_node
                assign w_g[gi] = w_prev_g[gi];
                assign w_p[gi] = w_prev_p[gi];
            end
        end
    end

    assign w_up_g = g_up[LOG_W-1].w_g;
    assign w_up_p = g_up[LOG_W-1].w_p;

    always_ff @(posedge clk) begin
        if (w_adv2 && r_vld_p1) begin
            r_g_p2  <= w_up_g;
            r_gp_p2 <= w_up_p;
            r_p_p2  <= r_p_p1;
            r_c0_p2 <= r_c0_p1;
        end
    end

    // ---- Stage 3: down-sweep, sum and borrow
    // Level spans shrink from WIDTH/4 to 1; each fills the midpoints between
    // positions that already hold a full prefix.
    for (gk = 0; gk < LOG_W - 1; gk++) begin : g_dn
        localparam int SPAN = 1 << (LOG_W - 2 - gk);
        logic [WIDTH-1:0] w_prev_g, w_prev_p, w_g, w_p;
        if (gk == 0) begin : g_src
            assign w_prev_g = r_g_p2;
            assign w_prev_p = r_gp_p2;
        end else begin : g_src
            assign w_prev_g = g_dn[gk-1].w_g;
            assign w_prev_p = g_dn[gk-1].w_p;
        end
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (((gi + 1) % (2 * SPAN)) == SPAN && gi >= 2 * SPAN) begin : g_node
                gp_t w_o;
                brent_kung_subtractor_pipe_gp_cell u_cell (
                    .i_hi (gp_t'({w_prev_g[gi], w_prev_p[gi]})),
                    .i_lo (gp_t'({w_prev_g[gi - SPAN], w_prev_p[gi - SPAN]})),
                    .o_gp (w_o)
                );
                assign w_g[gi] = w_o.g;
                assign w_p[gi] = w_o.p;
            end else begin : g_node
                assign w_g[gi] = w_prev_g[gi];
                assign w_p[gi] = w_prev_p[gi];
            end
        end
    end

    assign w_pre_g        = g_dn[LOG_W-2].w_g;
    assign w_unused_pre_p = g_dn[LOG_W-2].w_p;
    assign w_carry        = {w_pre_g[WIDTH-2:0], r_c0_p2};
    assign w_diff         = r_p_p2 ^ w_carry;
    assign w_borrow       = ~w_pre_g[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff_p3   <= '0;
            r_borrow_p3 <= 1'b0;
        end else if (w_adv3 && r_vld_p2) begin
            r_diff_p3   <= w_diff;
            r_borrow_p3 <= w_borrow;
        end
    end

    assign bus.out_valid  = r_vld_p3;
    assign bus.out_diff   = r_diff_p3;
    assign bus.out_borrow = r_borrow_p3;

endmodule

// File: tb/tb_brent_kung_subtractor_pipe.sv
module tb_brent_kung_subtractor_pipe;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    brent_kung_subtractor_pipe_if #(.WIDTH(W)) bus ();

    brent_kung_subtractor_pipe #(.WIDTH(W), .LOG_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [W:0] q [$];

    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    endfunction

    // Drives one bundle into an empty pipe with out_ready=1 and returns the
    // result plus the number of clock edges from acceptance until out_valid.
    task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                           output logic [W-1:0] d, output logic bo, output int lat);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_borrow = bin;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d  = bus.out_diff;
        bo = bus.out_borrow;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_diff !== '0) begin n_err++; $display("FAIL reset_out_diff got %h want 0", bus.out_diff); end
        n_vec++; if (bus.out_borrow !== 1'b0) begin n_err++; $display("FAIL reset_out_borrow got %b want 0", bus.out_borrow); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [9];
        logic [W-1:0] tb [9];
        logic [W-1:0] td [9];
        logic         tbin [9];
        logic         tbo [9];
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        ta[0] = 64'h3333_3333_3333_3333; tb[0] = 64'h3333_3333_3333_3331; tbin[0] = 0; td[0] = 64'h2;                  tbo[0] = 0;
        ta[1] = 64'h0;                   tb[1] = 64'h1;                   tbin[1] = 0; td[1] = 64'hFFFF_FFFF_FFFF_FFFF; tbo[1] = 1;
        ta[2] = 64'h5;                   tb[2] = 64'h5;                   tbin[2] = 1; td[2] = 64'hFFFF_FFFF_FFFF_FFFF; tbo[2] = 1;
        ta[3] = 64'hB333_3333_3333_333C; tb[3] = 64'hB333_3333_3333_3335; tbin[3] = 0; td[3] = 64'h7;                  tbo[3] = 0;
        ta[4] = 64'hB333_3333_3333_3335; tb[4] = 64'hB333_3333_3333_333C; tbin[4] = 0; td[4] = 64'hFFFF_FFFF_FFFF_FFF9; tbo[4] = 1;
        ta[5] = 64'hDEAD_BEEF_0123_4567; tb[5] = 64'hDEAD_BEEF_0123_4567; tbin[5] = 0; td[5] = 64'h0;                  tbo[5] = 0;
        ta[6] = 64'h0;                   tb[6] = 64'hFFFF_FFFF_FFFF_FFFF; tbin[6] = 1; td[6] = 64'h0;                  tbo[6] = 1;
        ta[7] = 64'hFFFF_FFFF_FFFF_FFFF; tb[7] = 64'h0;                   tbin[7] = 0; td[7] = 64'hFFFF_FFFF_FFFF_FFFF; tbo[7] = 0;
        ta[8] = 64'h8000_0000_0000_0000; tb[8] = 64'h1;                   tbin[8] = 1; td[8] = 64'h7FFF_FFFF_FFFF_FFFE; tbo[8] = 0;
        for (int i = 0; i < 9; i++) begin
            run_vec(ta[i], tb[i], tbin[i], d, bo, lat);
            n_vec++; if (d !== td[i]) begin n_err++; $display("FAIL directed[%0d] diff got %h want %h", i, d, td[i]); end
            n_vec++; if (bo !== tbo[i]) begin n_err++; $display("FAIL directed[%0d] borrow got %b want %b", i, bo, tbo[i]); end
            n_vec++; if (lat !== 3) begin n_err++; $display("FAIL directed[%0d] latency got %0d want 3", i, lat); end
            n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL directed[%0d] drained out_valid got %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int gaps = 0;
        int cyc = 0;
        logic started = 1'b0;
        logic acc;
        logic [W:0] exp;
        q.delete();
        bus.out_ready = 1'b1;
        bus.in_a      = {$urandom(), $urandom()};
        bus.in_b      = {$urandom(), $urandom()};
        bus.in_borrow = 1'($urandom_range(0, 1));
        bus.in_valid  = 1'b1;
        while (got < 1000 && cyc < 3000) begin
            @(negedge clk);
            if (bus.out_valid) begin
                started = 1'b1;
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL b2b unexpected result %h", bus.out_diff);
                end else begin
                    exp = q.pop_front();
                    if ({bus.out_borrow, bus.out_diff} !== exp) begin
                        n_err++; $display("FAIL b2b[%0d] result got %h want %h", got, {bus.out_borrow, bus.out_diff}, exp);
                    end
                end
                got++;
            end else if (started) begin
                gaps++;
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                q.push_back(ref_sub(bus.in_a, bus.in_b, bus.in_borrow));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (sent >= 1000) begin
                bus.in_valid = 1'b0;
            end else if (acc) begin
                bus.in_a      = {$urandom(), $urandom()};
                bus.in_b      = {$urandom(), $urandom()};
                bus.in_borrow = 1'($urandom_range(0, 1));
            end
        end
        n_vec++; if (got !== 1000) begin n_err++; $display("FAIL b2b_count got %0d want 1000", got); end
        n_vec++; if (gaps !== 0) begin n_err++; $display("FAIL b2b_gaps got %0d want 0", gaps); end
    endtask

    task automatic test_stall();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic exp_rdy;
        logic [W:0] held = '0;
        logic [W:0] obs;
        logic [W:0] exp;
        q.delete();
        bus.in_valid  = 1'($urandom_range(0, 9) < 8);
        bus.in_a      = {$urandom(), $urandom()};
        bus.in_b      = {$urandom(), $urandom()};
        bus.in_borrow = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 9) >= 3);
        while ((sent < 200 || q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            obs = {bus.out_borrow, bus.out_diff};
            if (prev_stall) begin
                n_vec++;
                if (bus.out_valid !== 1'b1 || obs !== held) begin
                    n_err++; $display("FAIL stall_hold valid %b data %h want valid 1 data %h", bus.out_valid, obs, held);
                end
            end
            exp_rdy = !(q.size() == 3 && !bus.out_ready);
            n_vec++;
            if (bus.in_ready !== exp_rdy) begin
                n_err++; $display("FAIL stall_in_ready got %b want %b (in flight %0d)", bus.in_ready, exp_rdy, q.size());
            end
            if (bus.out_valid && bus.out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL stall unexpected result %h", obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        n_err++; $display("FAIL stall[%0d] result got %h want %h", got, obs, exp);
                    end
                end
                got++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held = obs;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_sub(bus.in_a, bus.in_b, bus.in_borrow));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            bus.in_valid  = (sent < 200) ? 1'($urandom_range(0, 9) < 8) : 1'b0;
            bus.in_a      = {$urandom(), $urandom()};
            bus.in_b      = {$urandom(), $urandom()};
            bus.in_borrow = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 9) >= 3);
        end
        n_vec++; if (got !== 200) begin n_err++; $display("FAIL stall_count got %0d want 200", got); end
    endtask

    task automatic test_reset_flush();
        int seen = 0;
        logic [W-1:0] d;
        logic bo;
        int lat;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_a      = 64'h1111_0000_0000_0000 * (i + 1);
            bus.in_b      = 64'h0000_0000_0000_0042 + i;
            bus.in_borrow = 1'b0;
            bus.in_valid  = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_full out_valid %b in_ready %b want 1 0", bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_diff !== '0) begin n_err++; $display("FAIL flush_out_diff got %h want 0", bus.out_diff); end
        n_vec++; if (bus.out_borrow !== 1'b0) begin n_err++; $display("FAIL flush_out_borrow got %b want 0", bus.out_borrow); end
        bus.out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        @(posedge clk); #1;
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL flush_ghosts got %0d want 0", seen); end
        run_vec(64'h0000_0001_0000_0000, 64'h1, 1'b1, d, bo, lat);
        n_vec++; if (d !== 64'h0000_0000_FFFF_FFFE) begin n_err++; $display("FAIL flush_new diff got %h want 00000000fffffffe", d); end
        n_vec++; if (bo !== 1'b0) begin n_err++; $display("FAIL flush_new borrow got %b want 0", bo); end
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL flush_new latency got %0d want 3", lat); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_borrow = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
